spike_rate_decoder: RTL

- Output-side counterpart of the Bernoulli spike generator: turns the network's output spike trains back into values.
- Counts spikes per output neuron over a programmable window of clock cycles, then scans the counts sequentially to find the winning (most active) neuron.
- Exposes counts, winner and total through a word-addressed read port that the AXI config block muxes onto ext_mem_data_out.
- Sits between if_network spike_out and axi_cfg_regs.

---
 rtl/snn_pkg.sv | 21 ++
 rtl/sat_counter.sv | 20 ++
 rtl/spike_rate_decoder.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/snn_pkg.sv
// Shared types and constants for the spike-rate decoder: FSM states, read-map
// offsets and a width helper that never returns zero.
package snn_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        SCAN  = 2'd2,
        DONE  = 2'd3
    } decoder_state_t;

    // Read-map word offsets, relative to NUM_INPUTS
    localparam int unsigned RD_WINNER_OFS = 0;
    localparam int unsigned RD_TOTAL_OFS  = 1;
    localparam int unsigned RD_STATUS_OFS = 2;

    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/spike_rate_decoder.sv
// Counts output spikes per neuron over a programmable window, then scans the
// counts to find the most active neuron; results exposed on a word read port.
module spike_rate_decoder
    import snn_pkg::*;
#(
    parameter int unsigned NUM_INPUTS   = 4,
    parameter int unsigned COUNTER_SIZE = 8,
    parameter int unsigned WINDOW_WIDTH = 16
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [NUM_INPUTS-1:0]                spike_in,
    input  logic                                 start,
    input  logic [WINDOW_WIDTH-1:0]              window_len,
    output logic                                 busy,
    output logic                                 done,
    output logic [clog2_min1(NUM_INPUTS)-1:0]    winner_idx,
    output logic [COUNTER_SIZE-1:0]              winner_count,
    output logic                                 no_spikes,
    input  logic [31:0]                          mem_addr,
    output logic [31:0]                          mem_dout
);

    localparam int unsigned IDX_W   = clog2_min1(NUM_INPUTS);
    localparam int unsigned TOTAL_W = COUNTER_SIZE + $clog2(NUM_INPUTS) + 1;

    decoder_state_t          state;
    logic [WINDOW_WIDTH-1:0] timer;
    logic [IDX_W-1:0]        scan_idx;
    logic [IDX_W-1:0]        best_idx;
    logic [COUNTER_SIZE-1:0] best;
    logic [TOTAL_W-1:0]      total;
    logic [COUNTER_SIZE-1:0] counts [NUM_INPUTS];

    logic                    accept_c;
    logic                    count_en_c;
    logic                    scan_last_c;
    logic                    scan_take_c;
    logic [COUNTER_SIZE-1:0] scan_cnt_c;
    logic [31:0]             rd_data_c;

    assign accept_c    = start && ((state == IDLE) || (state == DONE));
    assign count_en_c  = (state == COUNT);
    assign scan_last_c = (scan_idx == IDX_W'(NUM_INPUTS - 1));
    assign scan_take_c = (scan_cnt_c > best);

    for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_cnt
        sat_counter #(
            .WIDTH (COUNTER_SIZE)
        ) u_cnt (
            .clk   (clk),
            .rst   (rst),
            .clr   (accept_c),
            .inc   (count_en_c && spike_in[i]),
            .count (counts[i])
        );
    end

    // Count selected by the scan index
    always_comb begin
        scan_cnt_c = '0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            if (scan_idx == IDX_W'(i)) scan_cnt_c = counts[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            timer        <= '0;
            scan_idx     <= '0;
            best_idx     <= '0;
            best         <= '0;
            total        <= '0;
            winner_idx   <= '0;
            winner_count <= '0;
            no_spikes    <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (accept_c) begin
                        timer    <= window_len;
                        total    <= '0;
                        scan_idx <= '0;
                        best_idx <= '0;
                        best     <= '0;
                        done     <= 1'b0;
                        busy     <= 1'b1;
                        state    <= (window_len == '0) ? SCAN : COUNT;
                    end
                end
                COUNT: begin
                    // The sample in the timer == 1 cycle is still counted
                    timer <= timer - WINDOW_WIDTH'(1);
                    if (timer == WINDOW_WIDTH'(1)) state <= SCAN;
                end
                SCAN: begin
                    total <= total + TOTAL_W'(scan_cnt_c);
                    if (scan_take_c) begin
                        best     <= scan_cnt_c;
                        best_idx <= scan_idx;
                    end
                    if (scan_last_c) begin
                        winner_idx   <= scan_take_c ? scan_idx : best_idx;
                        winner_count <= scan_take_c ? scan_cnt_c : best;
                        no_spikes    <= !scan_take_c && (best == '0);
                        busy         <= 1'b0;
                        done         <= 1'b1;
                        state        <= DONE;
                    end else begin
                        scan_idx <= scan_idx + IDX_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Word-addressed read mux
    always_comb begin
        rd_data_c = '0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            if (mem_addr == 32'(i)) rd_data_c = 32'(counts[i]);
        end
        if (mem_addr == 32'(NUM_INPUTS + RD_WINNER_OFS)) begin
            rd_data_c = {no_spikes, 7'b0, 8'(winner_count), 16'(winner_idx)};
        end
        if (mem_addr == 32'(NUM_INPUTS + RD_TOTAL_OFS)) begin
            rd_data_c = 32'(total);
        end
        if (mem_addr == 32'(NUM_INPUTS + RD_STATUS_OFS)) begin
            rd_data_c = {30'b0, busy, done};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) mem_dout <= '0;
        else     mem_dout <= rd_data_c;
    end

endmodule
